// File: rtl/ym_arb_pkg.sv
// Shared definitions for the 68k bus arbiter: FSM encoding, ACK-time winner ranks
// and the refresh backlog width.
package ym_arb_pkg;

    localparam int REF_PEND_W = 2;
    localparam logic [REF_PEND_W-1:0] REF_PEND_MAX = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_ACK  = 3'd2,
        ST_ZGNT = 3'd3,
        ST_DGNT = 3'd4,
        ST_REF  = 3'd5,
        ST_REL  = 3'd6
    } arb_state_e;

    // Winner classes in descending priority.
    typedef enum logic [2:0] {
        ARB_URGENT_REF = 3'd0,
        ARB_ALTERNATE  = 3'd1,
        ARB_DMA        = 3'd2,
        ARB_Z80        = 3'd3,
        ARB_REF        = 3'd4,
        ARB_NONE       = 3'd5
    } arb_pick_e;

    function automatic arb_pick_e arb_pick(input logic z_req, input logic d_req,
                                           input logic [REF_PEND_W-1:0] ref_pend);
        arb_pick_e p;
        if (ref_pend == REF_PEND_MAX) p = ARB_URGENT_REF;
        else if (z_req && d_req)      p = ARB_ALTERNATE;
        else if (d_req)               p = ARB_DMA;
        else if (z_req)               p = ARB_Z80;
        else if (ref_pend != '0)      p = ARB_REF;
        else                          p = ARB_NONE;
        return p;
    endfunction

endpackage

// File: rtl/ym_refresh_timer.sv
// Free-running refresh period counter with a saturating backlog of pending slots
// and a sticky flag for slots dropped while the backlog was full.
module ym_refresh_timer
    import ym_arb_pkg::*;
#(
    parameter int REF_PERIOD = 128
) (
    input  logic                  MCLK,
    input  logic                  rst,
    input  logic                  ref_dec,
    output logic [REF_PEND_W-1:0] ref_pend,
    output logic                  ref_ovf
);

    localparam int CW = $clog2(REF_PERIOD);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [REF_PEND_W-1:0] pend_q, pend_d;
    logic                  ovf_q, ovf_d;
    logic                  wrap;

    always_comb begin
        wrap   = (cnt_q == CW'(REF_PERIOD - 1));
        cnt_d  = wrap ? '0 : cnt_q + 1'b1;
        pend_d = pend_q;
        ovf_d  = ovf_q;
        // A wrap coinciding with a completed slot cancels out.
        if (wrap && !ref_dec) begin
            if (pend_q == REF_PEND_MAX) ovf_d = 1'b1;
            else                        pend_d = pend_q + 1'b1;
        end else if (!wrap && ref_dec && pend_q != '0) begin
            pend_d = pend_q - 1'b1;
        end
    end

    always_ff @(posedge MCLK or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    assign ref_pend = pend_q;
    assign ref_ovf  = ovf_q;

endmodule

// File: rtl/ym_bus_arbiter.sv
// Borrows the 68k bus via BR/BG/BGACK for the Z80 window, VDP DMA and refresh,
// one owner at a time, always handing the bus back to the 68k between owners.
module ym_bus_arbiter
    import ym_arb_pkg::*;
#(
    parameter int REF_PERIOD = 128,
    parameter int REF_LEN    = 4
) (
    input  logic                  MCLK,
    input  logic                  rst,
    input  logic                  z_req,
    input  logic                  z_done,
    input  logic                  d_req,
    input  logic                  d_done,
    input  logic                  bg_i,
    input  logic                  as_i,
    output logic                  br_o,
    output logic                  bgack_o,
    output logic                  z_gnt,
    output logic                  d_gnt,
    output logic                  ref_o,
    output logic [REF_PEND_W-1:0] ref_pend,
    output logic                  ref_ovf
);

    localparam int LW = (REF_LEN > 1) ? $clog2(REF_LEN) : 1;

    arb_state_e  state_q, state_d;
    logic        last_d_q, last_d_d;
    logic [LW-1:0] rlen_q, rlen_d;
    logic        br_q, br_d, bgack_q, bgack_d;
    logic        zg_q, zg_d, dg_q, dg_d, ref_q, ref_d;
    logic        ref_dec, any_req;

    ym_refresh_timer #(.REF_PERIOD(REF_PERIOD)) u_timer (
        .MCLK     (MCLK),
        .rst      (rst),
        .ref_dec  (ref_dec),
        .ref_pend (ref_pend),
        .ref_ovf  (ref_ovf)
    );

    always_comb begin
        any_req  = z_req | d_req | (ref_pend != '0);
        state_d  = state_q;
        last_d_d = last_d_q;
        rlen_d   = rlen_q;
        ref_dec  = 1'b0;
        case (state_q)
            ST_IDLE: if (any_req) state_d = ST_REQ;
            ST_REQ: begin
                if (bg_i && !as_i) state_d = ST_ACK;
                else if (!any_req) state_d = ST_IDLE;
            end
            ST_ACK: begin
                rlen_d = '0;
                case (arb_pick(z_req, d_req, ref_pend))
                    ARB_URGENT_REF, ARB_REF: state_d = ST_REF;
                    ARB_ALTERNATE:           state_d = last_d_q ? ST_ZGNT : ST_DGNT;
                    ARB_DMA:                 state_d = ST_DGNT;
                    ARB_Z80:                 state_d = ST_ZGNT;
                    default:                 state_d = ST_REL;
                endcase
            end
            ST_ZGNT: if (z_done || !z_req) begin
                state_d  = ST_REL;
                last_d_d = 1'b0;
            end
            ST_DGNT: if (d_done || !d_req) begin
                state_d  = ST_REL;
                last_d_d = 1'b1;
            end
            ST_REF: begin
                if (rlen_q == LW'(REF_LEN - 1)) begin
                    ref_dec = 1'b1;
                    state_d = ST_REL;
                end else begin
                    rlen_d = rlen_q + 1'b1;
                end
            end
            ST_REL:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        br_d    = (state_d == ST_REQ);
        bgack_d = (state_d inside {ST_ACK, ST_ZGNT, ST_DGNT, ST_REF});
        zg_d    = (state_d == ST_ZGNT);
        dg_d    = (state_d == ST_DGNT);
        ref_d   = (state_d == ST_REF);
    end

    always_ff @(posedge MCLK or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            last_d_q <= 1'b0;
            rlen_q   <= '0;
            br_q     <= 1'b0;
            bgack_q  <= 1'b0;
            zg_q     <= 1'b0;
            dg_q     <= 1'b0;
            ref_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            rlen_q   <= rlen_d;
            br_q     <= br_d;
            bgack_q  <= bgack_d;
            zg_q     <= zg_d;
            dg_q     <= dg_d;
            ref_q    <= ref_d;
        end
    end

    assign br_o    = br_q;
    assign bgack_o = bgack_q;
    assign z_gnt   = zg_q;
    assign d_gnt   = dg_q;
    assign ref_o   = ref_q;

endmodule

// File: tb/tb_ym_bus_arbiter.sv
// Bench for ym_bus_arbiter: a 68k responder echoes BR as BG one cycle late, and a
// scoreboard holds the expected order of Z80/DMA grants.
module tb_ym_bus_arbiter;

    localparam int REF_PERIOD = 16;
    localparam int REF_LEN    = 4;

    logic MCLK = 1'b0;
    logic rst = 1'b1;
    logic z_req = 1'b0, z_done = 1'b0, d_req = 1'b0, d_done = 1'b0;
    logic bg_i = 1'b0, as_i = 1'b0;
    logic br_o, bgack_o, z_gnt, d_gnt, ref_o, ref_ovf;
    logic [1:0] ref_pend;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int exp_q[$];   // 1 = Z80 grant, 2 = DMA grant

    ym_bus_arbiter #(.REF_PERIOD(REF_PERIOD), .REF_LEN(REF_LEN)) dut (
        .MCLK(MCLK), .rst(rst), .z_req(z_req), .z_done(z_done), .d_req(d_req),
        .d_done(d_done), .bg_i(bg_i), .as_i(as_i), .br_o(br_o), .bgack_o(bgack_o),
        .z_gnt(z_gnt), .d_gnt(d_gnt), .ref_o(ref_o), .ref_pend(ref_pend), .ref_ovf(ref_ovf)
    );

    always #5 MCLK = ~MCLK;
    always @(posedge MCLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    function automatic logic cond(input int sel);
        case (sel)
            0: return z_gnt;
            1: return d_gnt;
            2: return ref_o;
            3: return (ref_pend == 2'd0) && !ref_o;
            4: return z_gnt | d_gnt;
            5: return z_gnt | d_gnt | ref_o;
            6: return !ref_o;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int tmo, input string tag);
        int n = 0;
        while (!cond(sel) && n < tmo) begin
            @(negedge MCLK);
            n++;
        end
        chk(tag, cond(sel), 1);
    endtask

    task automatic serve(input int grants, input string tag);
        for (int i = 0; i < grants; i++) begin
            wait_for(4, 80, tag);
            if (d_gnt) begin
                tick(); d_done = 1'b1;
                tick(); d_done = 1'b0;
            end else begin
                tick(); z_done = 1'b1;
                tick(); z_done = 1'b0;
            end
        end
    endtask

    // 68k side: BG follows BR one cycle later.
    initial begin
        logic br_prev;
        br_prev = 1'b0;
        forever begin
            @(posedge MCLK);
            #1;
            bg_i    = br_prev;
            br_prev = br_o;
        end
    end

    // Per-cycle invariants, grant scoreboard, refresh pulse length, inter-grant gap.
    initial begin
        logic pz, pd, pr, pany, any;
        int idle_run, ref_run;
        bit seen;
        pz = 0; pd = 0; pr = 0; pany = 0; idle_run = 0; ref_run = 0; seen = 0;
        forever begin
            @(negedge MCLK);
            any = z_gnt | d_gnt | ref_o;
            chk("one_owner", $countones({z_gnt, d_gnt, ref_o}) <= 1, 1);
            chk("gnt_has_ack", any & ~bgack_o, 0);
            chk("br_ack_excl", br_o & bgack_o, 0);
            if (z_gnt && !pz) begin
                if (exp_q.size() == 0) chk("sb_unexpected", 1, 0);
                else                   chk("sb_grant", 1, exp_q.pop_front());
            end
            if (d_gnt && !pd) begin
                if (exp_q.size() == 0) chk("sb_unexpected", 2, 0);
                else                   chk("sb_grant", 2, exp_q.pop_front());
            end
            if (any && !pany) begin
                if (seen) chk("grant_gap", idle_run >= 3, 1);
                seen = 1;
            end
            if (any) idle_run = 0; else idle_run++;
            if (ref_o) ref_run++;
            else begin
                if (pr) chk("ref_len", ref_run, REF_LEN);
                ref_run = 0;
            end
            pz = z_gnt; pd = d_gnt; pr = ref_o; pany = any;
        end
    end

    initial begin
        int t0;
        repeat (3) @(posedge MCLK);
        @(negedge MCLK);
        chk("rst_br", br_o, 0);
        chk("rst_bgack", bgack_o, 0);
        chk("rst_zgnt", z_gnt, 0);
        chk("rst_dgnt", d_gnt, 0);
        chk("rst_ref", ref_o, 0);
        chk("rst_pend", ref_pend, 0);
        chk("rst_ovf", ref_ovf, 0);
        rst = 1'b0;

        // Single Z80 request: BR next cycle, ACK, grant 4 cycles after the request.
        tick(); z_req = 1'b1; exp_q.push_back(1);
        repeat (2) @(negedge MCLK);
        chk("t1_br", br_o, 1);
        repeat (2) @(negedge MCLK);
        chk("t1_ack", bgack_o, 1);
        chk("t1_ack_br", br_o, 0);
        chk("t1_ack_zgnt", z_gnt, 0);
        @(negedge MCLK);
        chk("t1_zgnt", z_gnt, 1);
        tick(); z_done = 1'b1; z_req = 1'b0;
        tick(); z_done = 1'b0;
        @(negedge MCLK);
        chk("t1_rel_zgnt", z_gnt, 0);
        chk("t1_rel_bgack", bgack_o, 0);
        chk("t1_rel_br", br_o, 0);
        @(negedge MCLK);
        chk("t1_idle_br", br_o, 0);

        // Both masters held: DMA first (last served was Z80), then alternate.
        tick(); z_req = 1'b1; d_req = 1'b1;
        exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(1);
        serve(4, "t2_gnt");
        tick(); z_req = 1'b0; d_req = 1'b0;

        // Idle bus: refresh drains, then steady pulses one period apart.
        wait_for(3, 200, "t3_drain");
        wait_for(2, 40, "t3_ref_a");
        t0 = cyc;
        wait_for(6, 10, "t3_ref_a_end");
        chk("t3_pend0", ref_pend, 0);
        wait_for(2, 40, "t3_ref_b");
        chk("t3_period_ab", cyc - t0, REF_PERIOD);
        t0 = cyc;
        wait_for(6, 10, "t3_ref_b_end");
        wait_for(2, 40, "t3_ref_c");
        chk("t3_period_bc", cyc - t0, REF_PERIOD);
        wait_for(6, 10, "t3_ref_c_end");

        // Long DMA hold saturates the backlog; urgent refresh beats the waiting Z80.
        chk("t4_ovf0", ref_ovf, 0);
        tick(); d_req = 1'b1; exp_q.push_back(2);
        wait_for(1, 40, "t4_dgnt");
        tick(); z_req = 1'b1; exp_q.push_back(1);
        repeat (70) @(negedge MCLK);
        chk("t4_dgnt_held", d_gnt, 1);
        chk("t4_pend3", ref_pend, 3);
        chk("t4_ovf1", ref_ovf, 1);
        tick(); d_req = 1'b0; d_done = 1'b1;
        tick(); d_done = 1'b0;
        wait_for(5, 40, "t4_next");
        chk("t4_ref_first", ref_o, 1);
        chk("t4_not_z", z_gnt, 0);
        wait_for(0, 80, "t4_zgnt");
        tick(); z_done = 1'b1; z_req = 1'b0;
        tick(); z_done = 1'b0;

        // Address strobe held: stay in REQ with BR up; ACK the cycle after AS drops.
        wait_for(3, 200, "t5_drain");
        tick(); as_i = 1'b1; z_req = 1'b1; exp_q.push_back(1);
        repeat (8) @(negedge MCLK);
        chk("t5_br_held", br_o, 1);
        chk("t5_no_ack", bgack_o, 0);
        chk("t5_no_zgnt", z_gnt, 0);
        tick(); as_i = 1'b0;
        repeat (2) @(negedge MCLK);
        chk("t5_ack", bgack_o, 1);
        chk("t5_ack_br", br_o, 0);
        wait_for(0, 10, "t5_zgnt");
        tick(); z_done = 1'b1; z_req = 1'b0;
        tick(); z_done = 1'b0;

        // Asynchronous reset mid-grant clears everything at once.
        tick(); d_req = 1'b1; exp_q.push_back(2);
        wait_for(1, 80, "t6_dgnt");
        chk("t6_ovf_sticky", ref_ovf, 1);
        @(posedge MCLK);
        #3 rst = 1'b1;
        #1;
        chk("t6_dgnt", d_gnt, 0);
        chk("t6_bgack", bgack_o, 0);
        chk("t6_br", br_o, 0);
        chk("t6_pend", ref_pend, 0);
        chk("t6_ovf", ref_ovf, 0);
        d_req = 1'b0;
        @(negedge MCLK);
        rst = 1'b0;
        repeat (3) @(negedge MCLK);
        chk("t6_idle_br", br_o, 0);
        chk("t6_idle_bgack", bgack_o, 0);
        // last_d is cleared by reset, so DMA wins the first tie again.
        tick(); z_req = 1'b1; d_req = 1'b1;
        exp_q.push_back(2); exp_q.push_back(1);
        serve(2, "t6_gnt");
        tick(); z_req = 1'b0; d_req = 1'b0;
        repeat (10) @(negedge MCLK);
        chk("sb_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
